// File: rtl/deconv_pkg.sv
// Shared types, constants and mod-16 helpers for the deconvolution block.
package deconv_pkg;

  localparam int unsigned NibbleW = 4;
  localparam int unsigned NumTaps = 4;

  typedef enum logic [1:0] {StIdle, StSolve, StCheck, StFin} deconv_state_e;

  // Nibble h holds h^-1 mod 16 (= h^3); even entries are unused and zero.
  localparam logic [63:0] InvTab = 64'hF050_3090_70D0_B010;

  function automatic logic [NibbleW-1:0] inv_lut(input logic [NibbleW-1:0] h);
    return InvTab[{h, 2'b00} +: NibbleW];
  endfunction

  function automatic logic [NibbleW-1:0] mul4(input logic [NibbleW-1:0] a,
                                               input logic [NibbleW-1:0] b);
    return a * b;
  endfunction

endpackage

// File: rtl/deconv_mac.sv
// Mod-16 sum of up to four 4-bit products; shared by the solve and check steps.
module deconv_mac
  import deconv_pkg::*;
(
  input  logic [NumTaps-1:0][NibbleW-1:0] a_i,
  input  logic [NumTaps-1:0][NibbleW-1:0] b_i,
  output logic [NibbleW-1:0]              sum_o
);

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < NumTaps; i++) begin
      sum_o = sum_o + mul4(a_i[i], b_i[i]);
    end
  end

endmodule

// File: rtl/deconvolution.sv
// Recovers a 4-tap x from y = h * x (mod 16). Define DECONV_CHECK_EN to verify y4..y6
// and the top nibble of A after the solve.
module deconvolution
  import deconv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mismatch
);

  deconv_state_e state_q, state_d;

  logic [NumTaps-1:0][NibbleW-1:0] h_q, x_q, mac_b;
  logic [7:0][NibbleW-1:0]         y_q;
  logic [NibbleW-1:0]              hinv_q, hinv_sel, y_sel, x_new, mac_sum;
  logic [2:0]                      k_q, k_eff;
  logic                            err_pend_q, done_q, err_q, mismatch_q;
  logic [31:0]                     result_q;
`ifdef DECONV_CHECK_EN
  logic                            mis_q;
`endif

  logic unused_b;
  assign unused_b = ^B[31:16];

  deconv_mac u_mac (
    .a_i  (h_q),
    .b_i  (mac_b),
    .sum_o(mac_sum)
  );

  // x0 is solved straight from the inputs on the accepting edge, so IDLE acts as k = 0.
  always_comb begin
    k_eff    = (state_q == StIdle) ? 3'd0 : k_q;
    y_sel    = (state_q == StIdle) ? A[3:0] : y_q[k_eff];
    hinv_sel = (state_q == StIdle) ? inv_lut(B[3:0]) : hinv_q;
    mac_b    = '0;
    for (int j = 1; j < NumTaps; j++) begin
      for (int i = 0; i < NumTaps; i++) begin
        if (int'(k_eff) == i + j) mac_b[j] = x_q[i];
      end
    end
    x_new = mul4(hinv_sel, y_sel - mac_sum);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = B[0] ? StSolve : StFin;
      StSolve: if (k_q == 3'd3) begin
`ifdef DECONV_CHECK_EN
        state_d = StCheck;
`else
        state_d = StFin;
`endif
      end
      StCheck: if (k_q == 3'd6) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= '0;
      y_q        <= '0;
      x_q        <= '0;
      hinv_q     <= '0;
      k_q        <= '0;
      err_pend_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mismatch_q <= 1'b0;
      result_q   <= '0;
`ifdef DECONV_CHECK_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: if (start) begin
          h_q        <= B[15:0];
          y_q        <= A;
          hinv_q     <= inv_lut(B[3:0]);
          x_q        <= {{(NumTaps-1)*NibbleW{1'b0}}, x_new};
          k_q        <= 3'd1;
          err_pend_q <= ~B[0];
`ifdef DECONV_CHECK_EN
          mis_q      <= 1'b0;
`endif
        end
        StSolve: begin
          x_q[k_q[1:0]] <= x_new;
          k_q           <= k_q + 3'd1;
        end
`ifdef DECONV_CHECK_EN
        StCheck: begin
          if (mac_sum != y_sel) mis_q <= 1'b1;
          k_q <= k_q + 3'd1;
        end
`endif
        StFin: begin
          done_q   <= 1'b1;
          err_q    <= err_pend_q;
          result_q <= err_pend_q ? 32'h0 : {16'h0, x_q};
`ifdef DECONV_CHECK_EN
          mismatch_q <= !err_pend_q && (mis_q || (y_q[7] != '0));
`else
          mismatch_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign Result   = result_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_deconvolution.sv
// Directed bench for deconvolution; expectations follow DECONV_CHECK_EN when defined.
module tb_deconvolution;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] A, B, Result;
  logic        busy, done, err, mismatch;

  int vectors = 0;
  int miscompares = 0;

`ifdef DECONV_CHECK_EN
  localparam int   LatOk = 7;
  localparam logic MisOn = 1'b1;
`else
  localparam int   LatOk = 4;
  localparam logic MisOn = 1'b0;
`endif

  deconvolution dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .Result  (Result),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, want);
    end
  endtask

  // Called at a negedge with start already driven; returns edges from sampling edge to done.
  task automatic wait_done(input bit hold, output int lat, output bit busy_ok);
    int idx;
    bit found;
    idx = 0;
    found = 1'b0;
    busy_ok = 1'b1;
    while (!found && idx < 40) begin
      @(negedge clk);
      if (idx == 0 && !hold) begin
        start = 1'b0;
        A = $urandom;
        B = $urandom;
      end
      if (done) found = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        idx++;
      end
    end
    lat = found ? idx : -1;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input logic [31:0] exp_res,
                     input logic exp_err, input logic exp_mis);
    int lat;
    bit bok;
    A = a;
    B = b;
    start = 1'b1;
    wait_done(1'b0, lat, bok);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".busy"}, {31'h0, bok}, 32'h1);
    chk({tag, ".result"}, Result, exp_res);
    chk({tag, ".err"}, {31'h0, err}, {31'h0, exp_err});
    chk({tag, ".mismatch"}, {31'h0, mismatch}, {31'h0, exp_mis});
    @(negedge clk);
    chk({tag, ".done_width"}, {31'h0, done}, 32'h0);
    chk({tag, ".busy_after"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int lat;
    int ndone;
    bit bok;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    #1;
    chk("reset.result", Result, 32'h0);
    chk("reset.flags", {28'h0, busy, done, err, mismatch}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("ident",  32'h00047531, 32'h00000011, LatOk, 32'h00004321, 1'b0, 1'b0);
    run("inv",    32'h0000C963, 32'h00000003, LatOk, 32'h00004321, 1'b0, 1'b0);
    run("noninv", 32'h00047531, 32'h00000002, 1,     32'h00000000, 1'b1, 1'b0);
    run("tail",   32'h00147531, 32'h00000011, LatOk, 32'h00004321, 1'b0, MisOn);
    run("topnib", 32'h10047531, 32'h00000011, LatOk, 32'h00004321, 1'b0, MisOn);
    run("wrap",   32'h00000001, 32'h0000000F, LatOk, 32'h0000000F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold.result", Result, 32'h0000000F);
    chk("hold.done", {31'h0, done}, 32'h0);
    run("taps",   32'h00894A41, 32'h00004321, LatOk, 32'h00004321, 1'b0, 1'b0);
    run("odd3",   32'h02E1455F, 32'hABCD2013, LatOk, 32'h00001705, 1'b0, 1'b0);

    // start held through the operation, then re-accepted in the done cycle
    A = 32'h00047531;
    B = 32'h00000011;
    start = 1'b1;
    wait_done(1'b1, lat, bok);
    chk("held.latency", lat, LatOk);
    chk("held.result", Result, 32'h00004321);
    A = 32'h00000001;
    B = 32'h0000000F;
    wait_done(1'b0, lat, bok);
    chk("b2b.latency", lat, LatOk);
    chk("b2b.result", Result, 32'h0000000F);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("b2b.extra_done", ndone, 0);

    // reset asserted while solving
    A = 32'h00047531;
    B = 32'h00000011;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.result", Result, 32'h0);
    chk("midrst.flags", {28'h0, busy, done, err, mismatch}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst.no_done", ndone, 0);
    chk("midrst.busy", {31'h0, busy}, 32'h0);
    run("postrst", 32'h00047531, 32'h00000011, LatOk, 32'h00004321, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
